// File: rtl/rf_pkg.sv
// Shared register-file constants, FSM state encoding and write-port payload type.
package rf_pkg;

    localparam int unsigned REG_COUNT  = 32;
    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned DATA_W     = 32;

    localparam logic [REG_ADDR_W-1:0] FIRST_REG = REG_ADDR_W'(1);
    localparam logic [REG_ADDR_W-1:0] LAST_REG  = REG_ADDR_W'(REG_COUNT - 1);

    typedef enum logic {
        ST_SWEEP = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [DATA_W-1:0]     data;
    } wr_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin grant: first valid requester at or after i_ptr, wrapping.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] i_valid,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_grant_c,
    output logic [IDX_W-1:0]   o_idx_c,
    output logic               o_any_c
);

    logic [2*NUM_REQ-1:0] w_dbl;
    logic [NUM_REQ-1:0]   w_rot;

    // Rotate so that the pointer position lands at bit 0.
    assign w_dbl = {i_valid, i_valid} >> i_ptr;
    assign w_rot = w_dbl[NUM_REQ-1:0];

    always_comb begin
        o_any_c   = |w_rot;
        o_idx_c   = '0;
        o_grant_c = '0;
        for (int j = int'(NUM_REQ) - 1; j >= 0; j--) begin
            if (w_rot[j]) begin
                o_idx_c = IDX_W'((int'(i_ptr) + j) % int'(NUM_REQ));
            end
        end
        for (int c = 0; c < int'(NUM_REQ); c++) begin
            o_grant_c[c] = o_any_c && (o_idx_c == IDX_W'(c));
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port controller: post-reset clear sweep of r1..r31, then
// round-robin sharing of the single write port among the writeback requesters.
module regfile_wb_arbiter
    import rf_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned IDX_W   = 2
) (
    input  logic                         clock,
    input  logic                         ctrl_reset_n,
    input  logic                         sweep_start,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [REG_ADDR_W*NUM_REQ-1:0] req_reg,
    input  logic [DATA_W*NUM_REQ-1:0]    req_data,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic                         ctrl_writeEnable,
    output logic [REG_ADDR_W-1:0]        ctrl_writeReg,
    output logic [DATA_W-1:0]            data_writeReg,
    output logic                         init_done
);

    state_t                r_state, w_state_nxt;
    logic [REG_ADDR_W-1:0] r_sweep_idx, w_idx_nxt;
    logic [IDX_W-1:0]      r_rr_ptr, w_ptr_nxt;
    logic                  r_we, w_we_nxt;
    wr_req_t               r_wr, w_wr_nxt;

    logic [NUM_REQ-1:0]    w_gnt;
    logic [IDX_W-1:0]      w_gidx;
    logic                  w_gany;
    logic                  w_run;
    logic                  w_hs;
    logic [REG_ADDR_W-1:0] w_issue_idx;
    wr_req_t               w_sel;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_arbiter (
        .i_valid   (req_valid),
        .i_ptr     (r_rr_ptr),
        .o_grant_c (w_gnt),
        .o_idx_c   (w_gidx),
        .o_any_c   (w_gany)
    );

    assign w_run       = (r_state == ST_RUN);
    assign w_hs        = w_run && w_gany;
    assign w_issue_idx = sweep_start ? FIRST_REG : r_sweep_idx;

    assign req_ready        = w_run ? w_gnt : '0;
    assign init_done        = w_run;
    assign ctrl_writeEnable = r_we;
    assign ctrl_writeReg    = r_wr.addr;
    assign data_writeReg    = r_wr.data;

    // Payload of the granted requester.
    always_comb begin
        w_sel = '0;
        for (int c = 0; c < int'(NUM_REQ); c++) begin
            if (w_gidx == IDX_W'(c)) begin
                w_sel.addr = req_reg[c*REG_ADDR_W +: REG_ADDR_W];
                w_sel.data = req_data[c*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_sweep_idx;
        w_ptr_nxt   = r_rr_ptr;
        w_we_nxt    = 1'b0;
        w_wr_nxt    = r_wr;
        case (r_state)
            ST_SWEEP: begin
                w_we_nxt = 1'b1;
                w_wr_nxt = '{addr: w_issue_idx, data: '0};
                if (w_issue_idx == LAST_REG) begin
                    w_state_nxt = ST_RUN;
                    w_idx_nxt   = FIRST_REG;
                end else begin
                    w_idx_nxt = w_issue_idx + REG_ADDR_W'(1);
                end
            end
            ST_RUN: begin
                if (w_hs) begin
                    w_ptr_nxt = IDX_W'((int'(w_gidx) + 1) % int'(NUM_REQ));
                    // r0 is hardwired zero: accept the request but suppress the write.
                    if (w_sel.addr != '0) begin
                        w_we_nxt = 1'b1;
                        w_wr_nxt = w_sel;
                    end
                end
                if (sweep_start) begin
                    w_state_nxt = ST_SWEEP;
                    w_idx_nxt   = FIRST_REG;
                end
            end
            default: begin
                w_state_nxt = ST_SWEEP;
                w_idx_nxt   = FIRST_REG;
            end
        endcase
    end

    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            r_state     <= ST_SWEEP;
            r_sweep_idx <= FIRST_REG;
            r_rr_ptr    <= '0;
            r_we        <= 1'b0;
            r_wr        <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_sweep_idx <= w_idx_nxt;
            r_rr_ptr    <= w_ptr_nxt;
            r_we        <= w_we_nxt;
            r_wr        <= w_wr_nxt;
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed vectors, sweep/reset corner
// cases and a randomized phase against a queue-free reference model.
module tb_regfile_wb_arbiter;

    localparam int N = 2;

    logic          clock = 1'b0;
    logic          ctrl_reset_n;
    logic          sweep_start;
    logic [N-1:0]  req_valid;
    logic [5*N-1:0]  req_reg;
    logic [32*N-1:0] req_data;
    logic [N-1:0]  req_ready;
    logic          ctrl_writeEnable;
    logic [4:0]    ctrl_writeReg;
    logic [31:0]   data_writeReg;
    logic          init_done;

    int checks = 0;
    int failures = 0;
    int zero_writes = 0;
    logic [31:0] shadow [32];
    logic [31:0] model_rf [32];

    always #5 clock = ~clock;

    regfile_wb_arbiter #(.NUM_REQ(N), .IDX_W(2)) dut (
        .clock            (clock),
        .ctrl_reset_n     (ctrl_reset_n),
        .sweep_start      (sweep_start),
        .req_valid        (req_valid),
        .req_reg          (req_reg),
        .req_data         (req_data),
        .req_ready        (req_ready),
        .ctrl_writeEnable (ctrl_writeEnable),
        .ctrl_writeReg    (ctrl_writeReg),
        .data_writeReg    (data_writeReg),
        .init_done        (init_done)
    );

    // Behaves like the register file: captures whatever the write port presents.
    always @(negedge clock) begin
        if (ctrl_writeEnable === 1'b1) begin
            shadow[ctrl_writeReg] <= data_writeReg;
            if (ctrl_writeReg == 5'd0) zero_writes <= zero_writes + 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [1:0] v, input logic [4:0] r0, input logic [31:0] d0,
                         input logic [4:0] r1, input logic [31:0] d1);
        req_valid = v;
        req_reg   = {r1, r0};
        req_data  = {d1, d0};
    endtask

    task automatic next_cycle();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic sweep_check(input logic [N-1:0] end_ready);
        for (int i = 1; i <= 31; i++) begin
            next_cycle();
            check("sweep_we", 32'(ctrl_writeEnable), 32'd1);
            check("sweep_addr", 32'(ctrl_writeReg), 32'(i));
            check("sweep_data", data_writeReg, 32'd0);
            check("sweep_ready", 32'(req_ready), (i == 31) ? 32'(end_ready) : 32'd0);
            check("sweep_init_done", 32'(init_done), (i == 31) ? 32'd1 : 32'd0);
        end
    endtask

    typedef struct {
        logic [1:0]  valid;
        logic [4:0]  r0;
        logic [31:0] d0;
        logic [4:0]  r1;
        logic [31:0] d1;
        logic [1:0]  ready;
        logic        we;
        logic [4:0]  addr;
        logic [31:0] data;
    } vec_t;

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt [7];
        logic [N-1:0]  pend;
        logic [4:0]    preg [N];
        logic [31:0]   pdata [N];
        int            m_ptr;
        int            g;
        logic          exp_we;
        logic [4:0]    exp_addr;
        logic [31:0]   exp_data;
        logic          found;

        // Outputs shown in each row are the result of the previous row's handshake.
        vt[0] = '{2'b10, 5'd0, 32'h0,  5'd0, 32'hFFFF_FFFF, 2'b10, 1'b0, 5'd5, 32'hDEAD_BEEF};
        vt[1] = '{2'b11, 5'd3, 32'h11, 5'd4, 32'h22,        2'b01, 1'b0, 5'd5, 32'hDEAD_BEEF};
        vt[2] = '{2'b11, 5'd3, 32'h11, 5'd4, 32'h22,        2'b10, 1'b1, 5'd3, 32'h11};
        vt[3] = '{2'b11, 5'd3, 32'h11, 5'd4, 32'h22,        2'b01, 1'b1, 5'd4, 32'h22};
        vt[4] = '{2'b11, 5'd3, 32'h11, 5'd4, 32'h22,        2'b10, 1'b1, 5'd3, 32'h11};
        vt[5] = '{2'b00, 5'd0, 32'h0,  5'd0, 32'h0,         2'b00, 1'b1, 5'd4, 32'h22};
        vt[6] = '{2'b00, 5'd0, 32'h0,  5'd0, 32'h0,         2'b00, 1'b0, 5'd4, 32'h22};

        ctrl_reset_n = 1'b0;
        sweep_start  = 1'b0;
        drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        #12;
        check("rst_we", 32'(ctrl_writeEnable), 32'd0);
        check("rst_addr", 32'(ctrl_writeReg), 32'd0);
        check("rst_data", data_writeReg, 32'd0);
        check("rst_init_done", 32'(init_done), 32'd0);
        check("rst_ready", 32'(req_ready), 32'd0);

        @(negedge clock);
        ctrl_reset_n = 1'b1;
        sweep_check(2'b00);

        // Single request after init.
        drive(2'b01, 5'd5, 32'hDEAD_BEEF, 5'd0, 32'h0);
        #1;
        check("single_ready", 32'(req_ready), 32'd1);
        next_cycle();
        drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        #1;
        check("single_we", 32'(ctrl_writeEnable), 32'd1);
        check("single_addr", 32'(ctrl_writeReg), 32'd5);
        check("single_data", data_writeReg, 32'hDEAD_BEEF);
        next_cycle();

        // r0 request, then alternating grants.
        for (int v = 0; v < 7; v++) begin
            drive(vt[v].valid, vt[v].r0, vt[v].d0, vt[v].r1, vt[v].d1);
            #1;
            check("tbl_ready", 32'(req_ready), 32'(vt[v].ready));
            check("tbl_we", 32'(ctrl_writeEnable), 32'(vt[v].we));
            check("tbl_addr", 32'(ctrl_writeReg), 32'(vt[v].addr));
            check("tbl_data", data_writeReg, vt[v].data);
            next_cycle();
        end

        // sweep_start coincident with a grant: grant completes, then a full sweep.
        drive(2'b01, 5'd7, 32'h77, 5'd0, 32'h0);
        sweep_start = 1'b1;
        #1;
        check("ss_ready", 32'(req_ready), 32'd1);
        next_cycle();
        sweep_start = 1'b0;
        drive(2'b01, 5'd8, 32'h88, 5'd0, 32'h0);
        #1;
        check("ss_we", 32'(ctrl_writeEnable), 32'd1);
        check("ss_addr", 32'(ctrl_writeReg), 32'd7);
        check("ss_data", data_writeReg, 32'h77);
        check("ss_ready_blocked", 32'(req_ready), 32'd0);
        check("ss_init_done", 32'(init_done), 32'd0);
        sweep_check(2'b01);
        next_cycle();
        drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        #1;
        check("ss_post_we", 32'(ctrl_writeEnable), 32'd1);
        check("ss_post_addr", 32'(ctrl_writeReg), 32'd8);
        check("ss_post_data", data_writeReg, 32'h88);

        // Reset in the middle of a sweep.
        sweep_start = 1'b1;
        next_cycle();
        sweep_start = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            next_cycle();
            if (ctrl_writeEnable === 1'b1 && ctrl_writeReg == 5'd17) found = 1'b1;
        end
        check("reach_idx17", 32'(found), 32'd1);
        #2;
        ctrl_reset_n = 1'b0;
        #1;
        check("midrst_we", 32'(ctrl_writeEnable), 32'd0);
        check("midrst_addr", 32'(ctrl_writeReg), 32'd0);
        check("midrst_init_done", 32'(init_done), 32'd0);
        @(negedge clock);
        ctrl_reset_n = 1'b1;
        sweep_check(2'b00);

        // Randomized phase against the reference model.
        model_rf[0] = 32'h0;
        for (int r = 1; r < 32; r++) model_rf[r] = 32'h0;
        m_ptr    = 0;
        pend     = '0;
        exp_we   = 1'b1;
        exp_addr = 5'd31;
        exp_data = 32'h0;
        for (int i = 0; i < N; i++) begin
            preg[i]  = 5'd0;
            pdata[i] = 32'h0;
        end
        for (int cyc = 0; cyc < 300; cyc++) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && ($urandom_range(0, 1) == 1)) begin
                    pend[i]  = 1'b1;
                    preg[i]  = 5'($urandom_range(0, 31));
                    pdata[i] = $urandom;
                end
            end
            drive(pend, preg[0], pdata[0], preg[1], pdata[1]);
            g = -1;
            for (int k = 0; k < N; k++) begin
                if (g < 0 && pend[(m_ptr + k) % N]) g = (m_ptr + k) % N;
            end
            #1;
            check("rnd_ready", 32'(req_ready), (g >= 0) ? (32'd1 << g) : 32'd0);
            check("rnd_we", 32'(ctrl_writeEnable), 32'(exp_we));
            if (exp_we) begin
                check("rnd_addr", 32'(ctrl_writeReg), 32'(exp_addr));
                check("rnd_data", data_writeReg, exp_data);
            end
            exp_we = 1'b0;
            if (g >= 0) begin
                pend[g] = 1'b0;
                m_ptr   = (g + 1) % N;
                if (preg[g] != 5'd0) begin
                    exp_we   = 1'b1;
                    exp_addr = preg[g];
                    exp_data = pdata[g];
                    model_rf[preg[g]] = pdata[g];
                end
            end
            next_cycle();
        end

        drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        next_cycle();
        next_cycle();
        for (int r = 1; r < 32; r++) begin
            check($sformatf("rf_r%0d", r), shadow[r], model_rf[r]);
        end
        check("r0_never_written", 32'(zero_writes), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Write-port controller for the 32x32 register file; sits between the writeback sources (ALU, mult/div, load unit) and the register file's single write port.
- Shares that write port among NUM_REQ requesters using round-robin arbitration with a valid/ready handshake.
- After reset, and on demand, runs a clear sweep that writes zero to registers 1..31 before any requester is served.
- Outputs are registered and drive the register file's ctrl_writeEnable, ctrl_writeReg and data_writeReg directly.

Parameters:
- NUM_REQ, 2, number of writeback requesters (2..4).
- IDX_W, 2, width of the round-robin pointer; must satisfy 2^IDX_W >= NUM_REQ.

Ports:
- clock  in  1  single system clock; all state updates on the rising edge.
- ctrl_reset_n  in  1  asynchronous, active-low reset.
- sweep_start  in  1  one-cycle pulse; starts (or restarts) the clear sweep.
- req_valid  in  NUM_REQ  per-requester write request.
- req_reg  in  5*NUM_REQ  destination register; requester i uses bits [5i+4:5i].
- req_data  in  32*NUM_REQ  write data; requester i uses bits [32i+31:32i].
- req_ready  out  NUM_REQ  one-hot grant; a handshake completes on a cycle where req_valid[i] and req_ready[i] are both 1.
- ctrl_writeEnable  out  1  register-file write enable.
- ctrl_writeReg  out  5  register-file write address.
- data_writeReg  out  32  register-file write data.
- init_done  out  1  high when no sweep is in progress.

Behaviour:
Reset
- ctrl_reset_n low asynchronously forces: state=SWEEP, sweep_idx=1, rr_ptr=0.
- Outputs during reset: ctrl_writeEnable=0, ctrl_writeReg=0, data_writeReg=0, init_done=0, req_ready=0.

State machine: SWEEP, RUN
- SWEEP: every cycle, register outputs WE=1, addr=sweep_idx, data=0; sweep_idx increments. When sweep_idx=31 is issued, next state is RUN.
- SWEEP: req_ready=0 throughout; a sweep issues 31 consecutive writes.
- RUN: init_done=1. sweep_start=1 → next state SWEEP with sweep_idx=1.
- sweep_start during SWEEP restarts the sweep at 1.
- sweep_start on the same cycle as a RUN grant: the grant still completes; the sweep begins the next cycle.

Arbitration (RUN)
- req_ready is combinational from req_valid and rr_ptr. Search starts at index rr_ptr and wraps modulo NUM_REQ; the first valid requester gets ready=1. At most one bit is set; ready=0 when no request is valid.
- On a handshake by requester g: rr_ptr <= (g+1) mod NUM_REQ. With no handshake, rr_ptr holds.
- Requesters must hold valid/reg/data stable until their handshake. The arbiter never drops an accepted request.

Write timing
- A handshake at cycle t produces ctrl_writeEnable=1, ctrl_writeReg=req_reg[g], data_writeReg=req_data[g] during cycle t+1.
- The register file captures the write at the end of cycle t+1, so latency is 1 cycle and throughput is 1 write per cycle.
- No handshake at t → ctrl_writeEnable=0 at t+1; ctrl_writeReg and data_writeReg hold their previous values.
- A request to register 0 is accepted (handshake completes, rr_ptr advances), but ctrl_writeEnable=0 at t+1; register 0 is never written.
- Two requesters targeting the same register: they are serialized in round-robin order, and the later write wins.
- Reset asserted mid-sweep or mid-write: any pending write is discarded (WE=0 immediately), and the sweep restarts after reset is released.

Decomposition:
- Shared package/include rf_pkg: REG_COUNT=32, REG_ADDR_W=5, DATA_W=32, state encodings ST_SWEEP=1'b0 and ST_RUN=1'b1.
- One sub-module, rr_arbiter: combinational round-robin grant from valid and pointer (NUM_REQ-wide), returning a one-hot grant and the granted index.
- The FSM, rr_ptr update and output registers live in the top module.

Test Plan:
- Release reset, hold all req_valid=0 → WE=1 for 31 cycles with ctrl_writeReg=1..31 and data=0; init_done rises the cycle after reg 31 is issued; req_ready=0 throughout.
- After init, valid[0]=1 (reg 5, data 0xDEADBEEF) for one cycle → ready[0]=1; next cycle WE=1, addr=5, data=0xDEADBEEF; the cycle after, WE=0.
- Both valid continuously (req0: reg 3/0x11, req1: reg 4/0x22), rr_ptr=0 → grants alternate 0,1,0,1; writes alternate (3,0x11),(4,0x22); neither requester starves.
- valid[1]=1 with reg=0, data=0xFFFFFFFF → ready[1]=1, rr_ptr becomes 0, WE stays 0.
- sweep_start pulse while req0 is valid in RUN → the req0 handshake completes that cycle, its write appears the next cycle, followed by a full 31-cycle sweep; ready=0 during the sweep; req0 is not re-granted until init_done=1.
- Assert ctrl_reset_n=0 mid-sweep at idx 17 → WE drops to 0 immediately; after release, the sweep restarts at 1.
